// File: rtl/flash_xip_reader_if.sv
// Request/response bus between the bus bridge (master) and the flash XIP read controller (slave).
interface flash_xip_reader_if #(
    parameter int ADDR_W = 24
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/flash_xip_reader.sv
// Single-word XIP read controller for a SPI mode-0 NOR flash: sends 03h + 24-bit address,
// shifts in 32 data bits and returns them little-endian.
module flash_xip_reader #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int ADDR_W     = 24
) (
    input  logic               clock,
    input  logic               reset,
    flash_xip_reader_if.slave  bus,
    output logic               spi_sck,
    output logic               spi_ss,
    output logic               spi_mosi,
    input  logic               spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        RESP,
        GAP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      tx_shift;
    logic [31:0]      rx_shift;
    logic [31:0]      frame_word;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      resp_data_q;
    logic             resp_err_q;
    logic             in_frame;
    logic             half_done;
    logic             accept;

    assign frame_word = {8'h03, 24'(bus.req_addr)};
    assign in_frame   = (state == CMD) || (state == ADDR) || (state == DATA);
    assign half_done  = in_frame && (div_cnt == DIV_LAST);
    assign accept     = (state == IDLE) && bus.req_valid && req_ready_q;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

    // NOTE: state registers use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= GAP_LOAD;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            spi_sck      <= 1'b0;
            spi_ss       <= 1'b1;
            spi_mosi     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        if (bus.req_addr[1:0] != 2'b00) begin
                            state       <= RESP;
                            resp_err_q  <= 1'b1;
                            resp_data_q <= '0;
                        end else begin
                            state    <= CMD;
                            spi_ss   <= 1'b0;
                            spi_sck  <= 1'b0;
                            spi_mosi <= frame_word[31];
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            bit_cnt <= bit_cnt + 7'd1;
                            if (state == CMD && bit_cnt == 7'd7)
                                state <= ADDR;
                            if (state == ADDR && bit_cnt == 7'd31)
                                state <= DATA;
                        end else if (bit_cnt == 7'd64) begin
                            // Frame ends: ss rises with sck low, gap timing starts here.
                            spi_sck     <= 1'b0;
                            spi_ss      <= 1'b1;
                            state       <= RESP;
                            resp_err_q  <= 1'b0;
                            resp_data_q <= {rx_shift[7:0], rx_shift[15:8],
                                            rx_shift[23:16], rx_shift[31:24]};
                            gap_cnt     <= GAP_LOAD;
                        end else begin
                            spi_sck  <= 1'b0;
                            spi_mosi <= (bit_cnt < 7'd32) ? tx_shift[30] : 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                RESP: begin
                    if (gap_cnt != '0)
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= GAP;
                        // No frame ran on the error path, so the gap is timed from here.
                        if (resp_err_q)
                            gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt     <= '0;
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    spi_ss      <= 1'b1;
                    spi_sck     <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the shift registers are pure datapath, loaded before use, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept)
            tx_shift <= frame_word;
        else if (half_done && spi_sck && bit_cnt < 7'd32)
            tx_shift <= {tx_shift[30:0], 1'b0};

        if (state == DATA && half_done && !spi_sck)
            rx_shift <= {rx_shift[30:0], spi_miso};
    end

endmodule

// File: tb/tb_flash_xip_reader.sv
// Self-checking bench for flash_xip_reader: behavioural SPI flash, table-driven reads with a
// response scoreboard, plus hand-written latency, backpressure, back-to-back and reset cases.
module tb_flash_xip_reader;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int ADDR_W     = 24;
    localparam int FRAME_LAT  = 64 * 2 * CLK_DIV + 2;
    localparam int ERR_LAT    = 2;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic spi_sck, spi_ss, spi_mosi;
    logic spi_miso = 1'b0;

    flash_xip_reader_if #(.ADDR_W(ADDR_W)) bus ();

    flash_xip_reader #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP_CYCLES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .spi_sck (spi_sck),
        .spi_ss  (spi_ss),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural flash: samples mosi on sck rise, drives miso after sck fall, resets on ss high.
    logic [7:0]  mem [0:511];
    logic [31:0] fl_in  = '0;
    logic [31:0] fl_cmd = '0;
    int fl_bits = 0;
    int fl_rises_last = 0;
    int frames = 0;

    always @(posedge spi_sck) begin
        if (spi_ss === 1'b0) begin
            if (fl_bits < 32) fl_in = {fl_in[30:0], spi_mosi};
            fl_bits++;
            if (fl_bits == 32) fl_cmd = fl_in;
        end
    end

    always @(negedge spi_sck) begin : flash_out
        int idx;
        int a;
        if (spi_ss === 1'b0 && fl_bits >= 32 && fl_bits < 64) begin
            idx = fl_bits - 32;
            a = (int'(fl_cmd[8:0]) + idx / 8) % 512;
            spi_miso = mem[a][7 - (idx % 8)];
        end
    end

    always @(posedge spi_ss) begin
        fl_rises_last = fl_bits;
        fl_bits = 0;
    end

    always @(negedge spi_ss) frames++;

    // Pin-timing monitor: sck half-period lengths and ss-high gap before each frame.
    int run = 0;
    int phase_bad = 0;
    int ss_high = 0;
    int last_gap = 0;
    logic in_frame = 1'b0;
    logic prev_sck = 1'b0;

    // Response side: latency measurement and scoreboard.
    vec_t exp_q[$];
    int resp_count = 0;
    int acc_cyc = 0;
    int last_lat = 0;
    logic prev_rv = 1'b0;

    always @(negedge clock) begin : monitors
        vec_t e;
        if (spi_ss === 1'b0) begin
            if (!in_frame) begin
                last_gap = ss_high;
                ss_high  = 0;
                run      = 1;
                in_frame = 1'b1;
            end else if (spi_sck != prev_sck) begin
                if (run != CLK_DIV) phase_bad++;
                run = 1;
            end else begin
                run++;
            end
            prev_sck = spi_sck;
        end else begin
            if (in_frame && run != CLK_DIV) phase_bad++;
            in_frame = 1'b0;
            ss_high++;
        end

        if (bus.resp_valid === 1'b1 && !prev_rv) last_lat = cyc - acc_cyc;
        prev_rv = (bus.resp_valid === 1'b1);

        if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got data 0x%0h with no request outstanding", bus.resp_data);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("resp_data@%0h", e.addr), bus.resp_data, e.data);
                check($sformatf("resp_err@%0h", e.addr), {31'd0, bus.resp_err}, {31'd0, e.err});
            end
            resp_count++;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the request.
    task automatic issue(input logic [23:0] a, input logic [31:0] d, input logic err);
        int n;
        n = 0;
        bus.req_addr  = a;
        bus.req_valid = 1'b1;
        exp_q.push_back('{a, d, err});
        @(negedge clock);
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("req_accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int t;
        t = 0;
        while (resp_count < target && t < 2000) begin
            @(posedge clock);
            t++;
        end
        check("resp_timeout", resp_count, target);
        #1;
    endtask

    vec_t vecs [8];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int frames0;
        int tgt;
        int t;
        int unstable;

        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        mem[256] = 8'h11;
        mem[257] = 8'h22;
        mem[258] = 8'h33;
        mem[259] = 8'h44;

        vecs[0] = '{24'h000100, 32'h44332211, 1'b0};
        vecs[1] = '{24'h000000, 32'h03020100, 1'b0};
        vecs[2] = '{24'h000004, 32'h07060504, 1'b0};
        vecs[3] = '{24'h000102, 32'h00000000, 1'b1};
        vecs[4] = '{24'h0000FC, 32'hFFFEFDFC, 1'b0};
        vecs[5] = '{24'h000001, 32'h00000000, 1'b1};
        vecs[6] = '{24'h000083, 32'h00000000, 1'b1};
        vecs[7] = '{24'h000040, 32'h43424140, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_data",  bus.resp_data,           32'd0);
        check("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
        check("rst_sck",        {31'd0, spi_sck},        32'd0);
        check("rst_ss",         {31'd0, spi_ss},         32'd1);
        check("rst_mosi",       {31'd0, spi_mosi},       32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single reads from the table, each run to completion.
        for (int i = 0; i < 8; i++) begin
            frames0 = frames;
            tgt = resp_count + 1;
            issue(vecs[i].addr, vecs[i].data, vecs[i].err);
            wait_resp(tgt);
            check($sformatf("latency@%0h", vecs[i].addr), last_lat,
                  vecs[i].err ? ERR_LAT : FRAME_LAT);
            check($sformatf("frames@%0h", vecs[i].addr), frames - frames0,
                  vecs[i].err ? 0 : 1);
            if (!vecs[i].err) begin
                check($sformatf("mosi_cmd@%0h", vecs[i].addr), fl_cmd, {8'h03, vecs[i].addr});
                check($sformatf("sck_rises@%0h", vecs[i].addr), fl_rises_last, 64);
            end
            repeat (3) @(posedge clock);
            #1;
        end

        // Back-to-back reads with the second request already pending.
        tgt = resp_count + 2;
        issue(24'h000000, 32'h03020100, 1'b0);
        issue(24'h000004, 32'h07060504, 1'b0);
        wait_resp(tgt);
        check("b2b_gap_ge_min", {31'd0, last_gap >= GAP_CYCLES}, 32'd1);

        // Backpressure: response held 20 cycles while a second request waits.
        bus.resp_ready = 1'b0;
        tgt = resp_count + 2;
        issue(24'h000100, 32'h44332211, 1'b0);
        bus.req_addr  = 24'h000004;
        bus.req_valid = 1'b1;
        exp_q.push_back('{24'h000004, 32'h07060504, 1'b0});
        t = 0;
        @(negedge clock);
        while (bus.resp_valid !== 1'b1 && t < 600) begin
            @(negedge clock);
            t++;
        end
        check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        unstable = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h44332211 ||
                bus.req_ready !== 1'b0 || spi_ss !== 1'b1)
                unstable++;
        end
        check("bp_stable", unstable, 0);
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b1;
        t = 0;
        @(negedge clock);
        while (bus.req_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("bp_second_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        wait_resp(tgt);
        check("bp_gap_ge_min", {31'd0, last_gap >= GAP_CYCLES}, 32'd1);
        check("sck_phase_len", phase_bad, 0);

        // Reset pulse at data bit 10 aborts the frame without a response.
        tgt = resp_count;
        issue(24'h000100, 32'h44332211, 1'b0);
        t = 0;
        while (fl_bits < 42 && t < 400) begin
            @(negedge clock);
            t++;
        end
        check("abort_reached_bit", {31'd0, fl_bits >= 42}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("abort_ss",         {31'd0, spi_ss},         32'd1);
        check("abort_sck",        {31'd0, spi_sck},        32'd0);
        check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("abort_req_ready",  {31'd0, bus.req_ready},  32'd1);
        repeat (5) @(posedge clock);
        #1;
        check("abort_no_resp", resp_count, tgt);
        tgt = resp_count + 1;
        issue(24'h000100, 32'h44332211, 1'b0);
        wait_resp(tgt);
        check("after_abort_latency", last_lat, FRAME_LAT);

        repeat (10) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
